regfile_alu_datapath: RTL and testbench

Execute-stage datapath slice of the multicycle MIPS CPU. It combines the 32x32 general-purpose register file with the R-type integer ALU. The ALU operands come straight from the two register read ports. The CPU controller drives the register addresses, write enable, write-back data and function code, then routes the ALU result (r) back to data_in for register write-back.

---
 rtl/regfile_alu_datapath.sv | 97 +++++++++
 tb/tb_regfile_alu_datapath.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_datapath.sv
// Execute-stage datapath slice: 32x32 register file feeding an R-type ALU.
// Read ports A/B drive the ALU operands directly; the controller loops the
// ALU result r back to data_in when it wants to write a result back.
module regfile_alu_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    input  logic [4:0]  write_addr,
    input  logic        write,
    input  logic [31:0] data_in,
    input  logic [5:0]  fncode,
    input  logic [4:0]  shamt,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] r,
    output logic [31:0] register_v0
);

    // R-type funct codes understood by the ALU.
    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_SRAV = 6'h07,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    // Register $zero has no storage; only indices 1..31 are real flops.
    logic [31:0] regs [1:31];

    // Register array: asynchronous clear, otherwise write on enabled edges.
    // NOTE: the array is reset on purpose -- software expects every GPR to
    // read 0 after reset, so this must be flops, not an uninitialised RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                // NOTE: non-blocking assignment for all sequential state so
                // every register updates from pre-edge values.
                regs[i] <= '0;
            end
        end else if (write && (write_addr != 5'd0)) begin
            regs[write_addr] <= data_in;
        end
    end

    // Combinational read ports; index 0 always reads as zero, no bypass.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through it can infer a latch.
        a           = '0;
        b           = '0;
        register_v0 = regs[2];
        if (addr_a != 5'd0) a = regs[addr_a];
        if (addr_b != 5'd0) b = regs[addr_b];
    end

    // Zero-latency ALU; variable shifts use only the low five bits of a.
    always_comb begin
        logic [4:0] var_sh;
        var_sh = a[4:0];
        r      = '0;
        case (fncode)
            FN_SLL:  r = b << shamt;
            FN_SRL:  r = b >> shamt;
            FN_SRA:  r = $unsigned($signed(b) >>> shamt);
            FN_SLLV: r = b << var_sh;
            FN_SRLV: r = b >> var_sh;
            FN_SRAV: r = $unsigned($signed(b) >>> var_sh);
            FN_JR:   r = a;
            FN_ADD,
            FN_ADDU: r = a + b;
            FN_SUB,
            FN_SUBU: r = a - b;
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_XOR:  r = a ^ b;
            FN_NOR:  r = ~(a | b);
            FN_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            FN_SLTU: r = {31'd0, (a < b)};
            default: r = '0;
        endcase
    end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Directed testbench for regfile_alu_datapath: register file behaviour,
// reset, read-during-write, ALU operations and the write-back loop.
module tb_regfile_alu_datapath;

    logic        clk;
    logic        reset;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  write_addr;
    logic        write;
    logic [31:0] data_in;
    logic [5:0]  fncode;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] register_v0;

    int errors = 0;
    int checks = 0;

    regfile_alu_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .write_addr  (write_addr),
        .write       (write),
        .data_in     (data_in),
        .fncode      (fncode),
        .shamt       (shamt),
        .a           (a),
        .b           (b),
        .r           (r),
        .register_v0 (register_v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single write cycle: set up after falling edge, commit on rising edge.
    task automatic do_write(input logic [4:0] wa, input logic [31:0] d);
        @(negedge clk);
        write_addr = wa;
        data_in    = d;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    // Apply operands and funct code, then let the combinational path settle.
    task automatic set_alu(input logic [4:0] ra, input logic [4:0] rb,
                           input logic [5:0] fn, input logic [4:0] sh);
        addr_a = ra;
        addr_b = rb;
        fncode = fn;
        shamt  = sh;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] exp_r;
        reset = 1'b1;
        #1;
        // While held in reset, operands are zero, so NOR gives all ones.
        set_alu(5'd0, 5'd0, 6'h27, 5'd0);
        exp_r = 32'hFFFF_FFFF;
        checks++;
        if (r !== exp_r) begin
            errors++;
            $display("FAIL reset_nor_zero: r=%h expected=%h", r, exp_r);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            addr_a = 5'(i);
            addr_b = 5'(31 - i);
            #1;
            checks++;
            if (a !== 32'd0 || b !== 32'd0) begin
                errors++;
                $display("FAIL reset_read idx=%0d: a=%h b=%h expected=0", i, a, b);
            end
        end
        checks++;
        if (register_v0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_v0: register_v0=%h expected=0", register_v0);
        end
    endtask

    task automatic test_write_read;
        do_write(5'd2, 32'h1234_5678);
        do_write(5'd0, 32'hDEAD_BEEF);
        set_alu(5'd0, 5'd2, 6'h21, 5'd0);
        checks++;
        if (register_v0 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_v0: register_v0=%h expected=12345678", register_v0);
        end
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL read_zero: a=%h expected=0", a);
        end
        checks++;
        if (b !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_b_reg2: b=%h expected=12345678", b);
        end
        // Disabled write must leave the target untouched.
        @(negedge clk);
        write_addr = 5'd2;
        data_in    = 32'hCAFE_F00D;
        write      = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (register_v0 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_disabled: register_v0=%h expected=12345678", register_v0);
        end
    endtask

    task automatic test_read_during_write;
        do_write(5'd5, 32'h0000_0011);
        @(negedge clk);
        addr_a     = 5'd5;
        write_addr = 5'd5;
        data_in    = 32'h0000_0022;
        write      = 1'b1;
        #1;
        checks++;
        if (a !== 32'h0000_0011) begin
            errors++;
            $display("FAIL rdw_before_edge: a=%h expected=00000011", a);
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        checks++;
        if (a !== 32'h0000_0022) begin
            errors++;
            $display("FAIL rdw_after_edge: a=%h expected=00000022", a);
        end
    endtask

    task automatic test_alu_arith;
        logic [5:0]  fns  [8];
        logic [31:0] exps [8];
        fns[0] = 6'h21; exps[0] = 32'h0000_0000;  // ADDU
        fns[1] = 6'h23; exps[1] = 32'hFFFF_FFFE;  // SUBU
        fns[2] = 6'h2A; exps[2] = 32'h0000_0001;  // SLT
        fns[3] = 6'h2B; exps[3] = 32'h0000_0000;  // SLTU
        fns[4] = 6'h27; exps[4] = 32'h0000_0000;  // NOR
        fns[5] = 6'h26; exps[5] = 32'hFFFF_FFFE;  // XOR
        fns[6] = 6'h24; exps[6] = 32'h0000_0001;  // AND
        fns[7] = 6'h22; exps[7] = 32'hFFFF_FFFE;  // SUB
        do_write(5'd1, 32'hFFFF_FFFF);
        do_write(5'd2, 32'h0000_0001);
        for (int i = 0; i < 8; i++) begin
            set_alu(5'd1, 5'd2, fns[i], 5'd0);
            checks++;
            if (r !== exps[i]) begin
                errors++;
                $display("FAIL arith fn=%h: r=%h expected=%h", fns[i], r, exps[i]);
            end
        end
        // Swapped operands: SLTU 1 < 0xFFFFFFFF is true, SLT 1 < -1 false.
        set_alu(5'd2, 5'd1, 6'h2B, 5'd0);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("FAIL sltu_swapped: r=%h expected=1", r);
        end
        set_alu(5'd2, 5'd1, 6'h2A, 5'd0);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL slt_swapped: r=%h expected=0", r);
        end
    endtask

    task automatic test_shifts;
        logic [5:0]  fns  [7];
        logic [4:0]  ra   [7];
        logic [31:0] exps [7];
        do_write(5'd6, 32'h8000_0010);  // b operand
        do_write(5'd7, 32'h0000_0024);  // a[4:0] = 4
        do_write(5'd8, 32'h0000_0020);  // a[4:0] = 0
        fns[0] = 6'h00; ra[0] = 5'd0; exps[0] = 32'h0000_0100;  // SLL 4
        fns[1] = 6'h02; ra[1] = 5'd0; exps[1] = 32'h0800_0001;  // SRL 4
        fns[2] = 6'h03; ra[2] = 5'd0; exps[2] = 32'hF800_0001;  // SRA 4
        fns[3] = 6'h07; ra[3] = 5'd7; exps[3] = 32'hF800_0001;  // SRAV
        fns[4] = 6'h04; ra[4] = 5'd7; exps[4] = 32'h0000_0100;  // SLLV
        fns[5] = 6'h06; ra[5] = 5'd7; exps[5] = 32'h0800_0001;  // SRLV
        fns[6] = 6'h07; ra[6] = 5'd8; exps[6] = 32'h8000_0010;  // SRAV by 0
        for (int i = 0; i < 7; i++) begin
            set_alu(ra[i], 5'd6, fns[i], 5'd4);
            checks++;
            if (r !== exps[i]) begin
                errors++;
                $display("FAIL shift fn=%h ra=%0d: r=%h expected=%h", fns[i], ra[i], r, exps[i]);
            end
        end
    endtask

    task automatic test_writeback_misc;
        do_write(5'd3, 32'd7);
        do_write(5'd4, 32'd9);
        set_alu(5'd3, 5'd4, 6'h21, 5'd0);
        do_write(5'd2, r);
        checks++;
        if (register_v0 !== 32'd16) begin
            errors++;
            $display("FAIL writeback_v0: register_v0=%h expected=00000010", register_v0);
        end
        do_write(5'd9, 32'hBFC0_0010);
        set_alu(5'd9, 5'd4, 6'h08, 5'd0);
        checks++;
        if (r !== 32'hBFC0_0010) begin
            errors++;
            $display("FAIL jr_passthrough: r=%h expected=bfc00010", r);
        end
        set_alu(5'd9, 5'd4, 6'h3F, 5'd0);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL undefined_fn: r=%h expected=0", r);
        end
    endtask

    task automatic test_reset_mid_cycle;
        // Reset raised between edges must clear state immediately.
        @(posedge clk);
        #2;
        reset  = 1'b1;
        addr_a = 5'd9;
        addr_b = 5'd4;
        #1;
        checks++;
        if (register_v0 !== 32'd0 || a !== 32'd0 || b !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: v0=%h a=%h b=%h expected=0", register_v0, a, b);
        end
        // Reset coincident with a write edge: reset wins.
        @(negedge clk);
        write_addr = 5'd10;
        data_in    = 32'h5555_AAAA;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        reset = 1'b0;
        addr_a = 5'd10;
        #1;
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL reset_beats_write: a=%h expected=0", a);
        end
    endtask

    initial begin
        reset      = 1'b1;
        addr_a     = '0;
        addr_b     = '0;
        write_addr = '0;
        write      = 1'b0;
        data_in    = '0;
        fncode     = '0;
        shamt      = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_alu_arith();
        test_shifts();
        test_writeback_misc();
        test_reset_mid_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
